bit_balancer_stream: RTL and testbench

Streaming, parametrised successor to the team's 8-bit registered ones-counter. Accepts WIDTH-bit words over a valid/ready handshake and computes a pipelined per-word population count. Accumulates the counts over a frame of up to FRAME_LEN words and reports the frame total, the signed ones/zeros disparity and a balanced flag. Sits between a line-coding source and the DC-balance monitor.

---
 rtl/bit_balancer_pkg.sv | 18 +
 rtl/bit_popcount_pipe.sv | 78 +++++++
 rtl/bit_balancer_stream.sv | 140 ++++++++++++++
 tb/tb_bit_balancer_stream.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_balancer_pkg.sv
// Shared types and width helpers for the bit_balancer_stream block.
package bit_balancer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } bb_state_t;

    function automatic int cw_f(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int tw_f(input int width, input int frame_len);
        return $clog2(width * frame_len + 1);
    endfunction

endpackage

// File: rtl/bit_popcount_pipe.sv
// Two-stage population count: S1 registers per-nibble partial counts, S2 sums them.
module bit_popcount_pipe
    import bit_balancer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter bit COUNT_ZEROS = 1'b0,
    localparam int CW         = cw_f(WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic [CW-1:0]    count,
    output logic             count_valid,
    output logic             count_last
);

    localparam int NIB = (WIDTH + 3) / 4;
    localparam int PW  = NIB * 4;

    logic [PW-1:0]    w_padded;
    logic [NIB*3-1:0] w_part;
    logic [CW-1:0]    w_sum;

    logic [NIB*3-1:0] r_part;
    logic             r_v1;
    logic             r_last1;
    logic [CW-1:0]    r_count;
    logic             r_valid;
    logic             r_last;

    // Inversion happens before padding so pad bits never count as zeros.
    always_comb begin
        w_padded = '0;
        w_padded[WIDTH-1:0] = COUNT_ZEROS ? ~in_data : in_data;
        w_part = '0;
        for (int i = 0; i < NIB; i++) begin
            w_part[i*3 +: 3] = 3'(w_padded[i*4])   + 3'(w_padded[i*4+1])
                             + 3'(w_padded[i*4+2]) + 3'(w_padded[i*4+3]);
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NIB; i++) begin
            w_sum = w_sum + CW'(r_part[i*3 +: 3]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_part  <= '0;
            r_v1    <= 1'b0;
            r_last1 <= 1'b0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (en) begin
            r_v1    <= in_valid;
            r_valid <= r_v1;
            if (in_valid) begin
                r_part  <= w_part;
                r_last1 <= in_last;
            end
            if (r_v1) begin
                r_count <= w_sum;
                r_last  <= r_last1;
            end
        end
    end

    assign count       = r_count;
    assign count_valid = r_valid;
    assign count_last  = r_last;

endmodule

// File: rtl/bit_balancer_stream.sv
// Streaming popcount with per-frame accumulation, ones/zeros disparity and balance flag.
// Handshake: a word moves on a rising edge with in_valid && in_ready; the frame result
// is held while frame_valid is high and retires on the edge where frame_ready is also high.
module bit_balancer_stream
    import bit_balancer_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int FRAME_LEN   = 8,
    parameter bit COUNT_ZEROS = 1'b0,
    localparam int CW         = cw_f(WIDTH),
    localparam int TW         = tw_f(WIDTH, FRAME_LEN),
    localparam int FW         = $clog2(FRAME_LEN + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [CW-1:0]       word_count,
    output logic                word_valid,
    output logic [TW-1:0]       frame_total,
    output logic [FW-1:0]       frame_words,
    output logic signed [TW:0]  frame_disp,
    output logic                frame_balanced,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [1:0]          dbg_state
);

    localparam int DW = TW + 1;

    bb_state_t         r_state;
    bb_state_t         w_state_nxt;
    logic              r_run;
    logic [TW-1:0]     r_acc;
    logic [TW-1:0]     w_acc_nxt;
    logic [TW-1:0]     w_base_acc;
    logic [FW-1:0]     r_words;
    logic [FW-1:0]     w_words_nxt;
    logic [FW-1:0]     w_base_words;
    logic signed [TW:0] r_disp;
    logic signed [TW:0] w_disp_nxt;
    logic              r_bal;
    logic              w_bal_nxt;
    logic [DW-1:0]     w_span;
    logic [DW-1:0]     w_ones;

    logic              w_adv;
    logic              w_take;
    logic [CW-1:0]     w_count;
    logic              w_cvalid;
    logic              w_clast;

    assign frame_valid = (r_state == HOLD);
    assign w_adv       = !(frame_valid && !frame_ready);
    assign in_ready    = r_run && w_adv;
    assign w_take      = in_valid && in_ready;

    bit_popcount_pipe #(
        .WIDTH       (WIDTH),
        .COUNT_ZEROS (COUNT_ZEROS)
    ) u_pipe (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (w_adv),
        .in_data     (in_data),
        .in_valid    (w_take),
        .in_last     (in_last),
        .count       (w_count),
        .count_valid (w_cvalid),
        .count_last  (w_clast)
    );

    // Only evaluated into the registers when w_adv is high, so in HOLD the
    // frame_ready handshake is implied: retire first, then let a word in S2 open
    // the next frame on the same edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_base_acc   = r_acc;
        w_base_words = r_words;
        w_acc_nxt    = r_acc;
        w_words_nxt  = r_words;
        w_disp_nxt   = r_disp;
        w_bal_nxt    = r_bal;
        w_span       = '0;
        w_ones       = '0;
        if (r_state == HOLD) begin
            w_state_nxt  = IDLE;
            w_base_acc   = '0;
            w_base_words = '0;
            w_disp_nxt   = '0;
            w_bal_nxt    = 1'b0;
        end
        w_acc_nxt   = w_base_acc;
        w_words_nxt = w_base_words;
        if (w_cvalid) begin
            w_acc_nxt   = w_base_acc + TW'(w_count);
            w_words_nxt = w_base_words + FW'(1);
            w_span      = DW'(WIDTH) * DW'(w_words_nxt);
            w_ones      = COUNT_ZEROS ? (w_span - DW'(w_acc_nxt)) : DW'(w_acc_nxt);
            if (w_clast || (w_words_nxt == FW'(FRAME_LEN))) begin
                w_state_nxt = HOLD;
                w_disp_nxt  = $signed((w_ones << 1) - w_span);
                w_bal_nxt   = ((w_ones << 1) == w_span);
            end else begin
                w_state_nxt = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run   <= 1'b0;
            r_state <= IDLE;
            r_acc   <= '0;
            r_words <= '0;
            r_disp  <= '0;
            r_bal   <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_adv) begin
                r_state <= w_state_nxt;
                r_acc   <= w_acc_nxt;
                r_words <= w_words_nxt;
                r_disp  <= w_disp_nxt;
                r_bal   <= w_bal_nxt;
            end
        end
    end

    assign word_count     = w_count;
    assign word_valid     = w_cvalid;
    assign frame_total    = r_acc;
    assign frame_words    = r_words;
    assign frame_disp     = r_disp;
    assign frame_balanced = r_bal;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_bit_balancer_stream.sv
// Bench for bit_balancer_stream: a ones-counting and a zeros-counting instance share one stream.
module tb_bit_balancer_stream;

    localparam int W  = 16;
    localparam int FL = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [W-1:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        frame_ready = 1'b1;

    logic        in_ready [2];
    logic [4:0]  word_count [2];
    logic        word_valid [2];
    logic [6:0]  frame_total [2];
    logic [2:0]  frame_words [2];
    logic signed [7:0] frame_disp [2];
    logic        frame_balanced [2];
    logic        frame_valid [2];
    logic [1:0]  dbg_state [2];

    int checks = 0;
    int errors = 0;

    int exp_cnt_q [2][$];
    int exp_stamp_q [2][$];
    int exp_tot_q [2][$];
    int exp_wds_q [2][$];
    int exp_disp_q [2][$];

    int adv_edges [2] = '{0, 0};
    bit seen [2] = '{1'b0, 1'b0};
    bit run_ok = 1'b0;
    bit mon_en = 1'b0;
    int m_ones = 0;
    int m_words = 0;
    int fr_mode = 0;
    int stall_cnt = 0;

    bit_balancer_stream #(.WIDTH(W), .FRAME_LEN(FL), .COUNT_ZEROS(1'b0)) dut_ones (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready[0]), .word_count(word_count[0]),
        .word_valid(word_valid[0]), .frame_total(frame_total[0]),
        .frame_words(frame_words[0]), .frame_disp(frame_disp[0]),
        .frame_balanced(frame_balanced[0]), .frame_valid(frame_valid[0]),
        .frame_ready(frame_ready), .dbg_state(dbg_state[0])
    );

    bit_balancer_stream #(.WIDTH(W), .FRAME_LEN(FL), .COUNT_ZEROS(1'b1)) dut_zeros (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready[1]), .word_count(word_count[1]),
        .word_valid(word_valid[1]), .frame_total(frame_total[1]),
        .frame_words(frame_words[1]), .frame_disp(frame_disp[1]),
        .frame_balanced(frame_balanced[1]), .frame_valid(frame_valid[1]),
        .frame_ready(frame_ready), .dbg_state(dbg_state[1])
    );

    // ---------------- clock / reset-side bookkeeping ----------------
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) run_ok <= 1'b0;
        else          run_ok <= 1'b1;
    end

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset_n && !(frame_valid[g] && !frame_ready))
                adv_edges[g] <= adv_edges[g] + 1;
        end
    end

    function automatic void chk(input string name, input int g, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, g, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    task automatic model_accept(input logic [W-1:0] d, input logic l);
        int ones;
        ones = $countones(d);
        for (int g = 0; g < 2; g++) begin
            exp_cnt_q[g].push_back(g == 0 ? ones : W - ones);
            exp_stamp_q[g].push_back(adv_edges[g]);
        end
        m_ones  += ones;
        m_words += 1;
        if (l || m_words == FL) begin
            for (int g = 0; g < 2; g++) begin
                exp_tot_q[g].push_back(g == 0 ? m_ones : W * m_words - m_ones);
                exp_wds_q[g].push_back(m_words);
                exp_disp_q[g].push_back(2 * m_ones - W * m_words);
            end
            m_ones  = 0;
            m_words = 0;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_word(input logic [W-1:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        #1;
        while (!(in_ready[0] && in_ready[1]) && n < 200) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (n >= 200) begin
            chk("accept_timeout", 0, n, 0);
            in_valid = 1'b0;
        end else begin
            model_accept(d, l);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        #3;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int g = 0; g < 2; g++) begin
            exp_cnt_q[g].delete();
            exp_stamp_q[g].delete();
            exp_tot_q[g].delete();
            exp_wds_q[g].delete();
            exp_disp_q[g].delete();
            seen[g] = 1'b0;
        end
        m_ones  = 0;
        m_words = 0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_in_ready", g, in_ready[g], 0);
            chk("rst_word_valid", g, word_valid[g], 0);
            chk("rst_word_count", g, word_count[g], 0);
            chk("rst_frame_valid", g, frame_valid[g], 0);
            chk("rst_frame_total", g, frame_total[g], 0);
            chk("rst_frame_words", g, frame_words[g], 0);
            chk("rst_frame_disp", g, frame_disp[g], 0);
            chk("rst_frame_bal", g, frame_balanced[g], 0);
        end
        repeat (hold) @(negedge clk);
        #3;
        reset_n = 1'b1;
        mon_en  = 1'b1;
    endtask

    // ---------------- frame_ready driver ----------------
    initial begin
        forever begin
            @(negedge clk);
            case (fr_mode)
                1: frame_ready = ($urandom_range(0, 9) < 7);
                2: begin
                    if (stall_cnt >= 5) begin
                        frame_ready = 1'b1;
                        fr_mode = 0;
                    end else begin
                        frame_ready = 1'b0;
                        if (frame_valid[0] === 1'b1) stall_cnt++;
                    end
                end
                default: frame_ready = 1'b1;
            endcase
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit adv;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && reset_n) begin
                for (int g = 0; g < 2; g++) begin
                    adv = !(frame_valid[g] && !frame_ready);
                    chk("in_ready_rule", g, in_ready[g], run_ok && adv);
                    if (word_valid[g]) begin
                        chk("word_expected", g, exp_cnt_q[g].size() != 0, 1);
                        if (exp_cnt_q[g].size() != 0) begin
                            if (!seen[g]) begin
                                chk("word_latency", g, adv_edges[g], exp_stamp_q[g][0] + 2);
                                seen[g] = 1'b1;
                            end
                            if (adv) begin
                                chk("word_count", g, word_count[g], exp_cnt_q[g][0]);
                                void'(exp_cnt_q[g].pop_front());
                                void'(exp_stamp_q[g].pop_front());
                                seen[g] = 1'b0;
                            end
                        end
                    end
                    if (frame_valid[g]) begin
                        chk("frame_expected", g, exp_tot_q[g].size() != 0, 1);
                        if (exp_tot_q[g].size() != 0) begin
                            chk("frame_total", g, frame_total[g], exp_tot_q[g][0]);
                            chk("frame_words", g, frame_words[g], exp_wds_q[g][0]);
                            chk("frame_disp", g, longint'(frame_disp[g]), exp_disp_q[g][0]);
                            chk("frame_balanced", g, frame_balanced[g], exp_disp_q[g][0] == 0);
                            if (frame_ready) begin
                                void'(exp_tot_q[g].pop_front());
                                void'(exp_wds_q[g].pop_front());
                                void'(exp_disp_q[g].pop_front());
                            end
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        do_reset(2);

        // Back-to-back balanced frame, then an early-closed frame right behind it.
        fr_mode = 0;
        send_word(16'h0000, 1'b0);
        send_word(16'hFFFF, 1'b0);
        send_word(16'h00FF, 1'b0);
        send_word(16'hAAAA, 1'b0);
        send_word(16'hFFFF, 1'b0);
        send_word(16'h0001, 1'b1);
        idle(6);

        // Consumer stalls on a full frame while the next word waits at the input.
        stall_cnt = 0;
        fr_mode   = 2;
        repeat (4) send_word(16'h0000, 1'b0);
        send_word(16'h0F0F, 1'b1);
        idle(6);

        // All-zero frame, exercised for both counting polarities.
        fr_mode = 0;
        repeat (4) send_word(16'h0000, 1'b0);
        idle(4);

        // Reset in the middle of a frame discards it.
        send_word(16'hFFFF, 1'b0);
        send_word(16'hFFFF, 1'b0);
        do_reset(3);
        repeat (4) send_word(16'hFFFF, 1'b0);
        idle(4);

        // Frame retirement coinciding with the first word of the next frame.
        repeat (5) send_word(16'h1234, 1'b0);
        send_word(16'h8001, 1'b1);
        idle(4);

        // Randomized stream with random gaps, early closes and consumer back-pressure.
        fr_mode = 1;
        for (int i = 0; i < 250; i++) begin
            send_word(W'($urandom), $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        // Close any open frame so nothing is left pending.
        send_word(W'($urandom), 1'b1);
        fr_mode = 0;
        idle(20);

        for (int g = 0; g < 2; g++) begin
            chk("leftover_words", g, exp_cnt_q[g].size(), 0);
            chk("leftover_frames", g, exp_tot_q[g].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
